// File: rtl/register_bus_arbiter_if.sv
// ============================================================================
// register_bus_arbiter_if : two-master request side plus register bus signals
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface register_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_write;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_write;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;

`ifdef REG_ARB_LOCK_EN
  logic                  m0_lock;
  logic                  m1_lock;
`endif

  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] bus_address;
  logic                  bus_write_enable;
  logic [DATA_WIDTH-1:0] bus_write_data;
  logic                  bus_read_enable;
  logic [DATA_WIDTH-1:0] bus_read_data;

  // Arbiter side
  modport slave (
`ifdef REG_ARB_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  bus_read_data,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output grant, bus_address, bus_write_enable, bus_write_data, bus_read_enable
  );

  // Requesting masters and register block side
  modport master (
`ifdef REG_ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output bus_read_data,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  grant, bus_address, bus_write_enable, bus_write_data, bus_read_enable
  );

endinterface

`default_nettype wire

// File: rtl/register_bus_arbiter.sv
// ============================================================================
// register_bus_arbiter : round-robin two-master arbiter for one register bus
// Rev 1.0 : initial release (optional bus lock via REG_ARB_LOCK_EN)
// ============================================================================
`default_nettype none

module register_bus_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic              clock,
  input  wire logic              reset,
  register_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state,  w_state_nxt;
  logic [1:0]            r_grant,  w_grant_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,  w_wdata_nxt;
  logic                  r_we,     w_we_nxt;
  logic                  r_re,     w_re_nxt;
  logic [1:0]            r_ack,    w_ack_nxt;
  logic [DATA_WIDTH-1:0] r_rdata0, w_rdata0_nxt;
  logic [DATA_WIDTH-1:0] r_rdata1, w_rdata1_nxt;
  logic                  r_last,   w_last_nxt;   // 1 = master 1 won last

  logic                  w_any;
  logic                  w_win;                  // 1 = master 1 wins

`ifdef REG_ARB_LOCK_EN
  logic                  r_lock_hold, w_lock_hold_nxt;
  logic                  w_lock_act;

  // The lock owner is always the last winner, so r_last names it.
  assign w_lock_act = r_lock_hold &&
                      (r_last ? (bus.m1_lock && bus.m1_req)
                              : (bus.m0_lock && bus.m0_req));
`endif

  assign w_any = bus.m0_req | bus.m1_req;

  always_comb begin
    w_win = bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      w_win = ~r_last;
    end
`ifdef REG_ARB_LOCK_EN
    if (w_lock_act) begin
      w_win = r_last;
    end
`endif
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = 1'b0;
    w_re_nxt     = 1'b0;
    w_ack_nxt    = 2'b00;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_last_nxt   = r_last;
`ifdef REG_ARB_LOCK_EN
    w_lock_hold_nxt = r_lock_hold;
`endif

    case (r_state)
      S_IDLE: begin
        w_grant_nxt = 2'b00;
`ifdef REG_ARB_LOCK_EN
        w_lock_hold_nxt = w_lock_act;
`endif
        if (w_any) begin
          w_grant_nxt = w_win ? 2'b10 : 2'b01;
          w_addr_nxt  = w_win ? bus.m1_addr  : bus.m0_addr;
          w_wdata_nxt = w_win ? bus.m1_wdata : bus.m0_wdata;
          w_we_nxt    = w_win ? bus.m1_write  : bus.m0_write;
          w_re_nxt    = w_win ? ~bus.m1_write : ~bus.m0_write;
          w_state_nxt = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (r_re) begin
          if (r_grant[1]) begin
            w_rdata1_nxt = bus.bus_read_data;
          end else begin
            w_rdata0_nxt = bus.bus_read_data;
          end
        end
        w_ack_nxt   = r_grant;
        w_state_nxt = S_RESP;
      end

      S_RESP: begin
        w_grant_nxt = 2'b00;
        w_last_nxt  = r_grant[1];
`ifdef REG_ARB_LOCK_EN
        w_lock_hold_nxt = r_grant[1] ? bus.m1_lock : bus.m0_lock;
`endif
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_grant  <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_ack    <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_last   <= 1'b1;
`ifdef REG_ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_re     <= w_re_nxt;
      r_ack    <= w_ack_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_last   <= w_last_nxt;
`ifdef REG_ARB_LOCK_EN
      r_lock_hold <= w_lock_hold_nxt;
`endif
    end
  end

  assign bus.grant            = r_grant;
  assign bus.bus_address      = r_addr;
  assign bus.bus_write_data   = r_wdata;
  assign bus.bus_write_enable = r_we;
  assign bus.bus_read_enable  = r_re;
  assign bus.m0_ack           = r_ack[0];
  assign bus.m1_ack           = r_ack[1];
  assign bus.m0_rdata         = r_rdata0;
  assign bus.m1_rdata         = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_register_bus_arbiter.sv
// ============================================================================
// tb_register_bus_arbiter : directed self-checking bench for register_bus_arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_register_bus_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_wr30  = 0;

  always #5 clock = ~clock;

  register_bus_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  register_bus_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Register block model: read data is the address XOR 9
  assign bus.bus_read_data = {24'h0, bus.bus_address} ^ 32'h0000_0009;

  always @(posedge clock) begin
    if (bus.bus_write_enable && bus.bus_address == 8'h30) n_wr30++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, {30'h0, bus.grant}, 32'h0);
    chk({tag, "_ack0"},  {31'h0, bus.m0_ack}, 32'h0);
    chk({tag, "_ack1"},  {31'h0, bus.m1_ack}, 32'h0);
    chk({tag, "_we"},    {31'h0, bus.bus_write_enable}, 32'h0);
    chk({tag, "_re"},    {31'h0, bus.bus_read_enable}, 32'h0);
  endtask

  // Both masters reading continuously; lock_tr = number of leading m0 wins
  task automatic run_both(input string tag, input int ncyc, input int lock_tr, input int drop_at);
    for (int c = 1; c <= ncyc; c++) begin
      int         tr;
      int         ph;
      logic       w;
      logic [1:0] oh;
      tick();
      tr = (c - 1) / 3;
      ph = (c - 1) % 3;
      w  = (lock_tr > 0) ? (tr >= lock_tr) : tr[0];
      oh = w ? 2'b10 : 2'b01;
      chk({tag, "_acks"},  {30'h0, bus.m1_ack, bus.m0_ack}, (ph == 1) ? {30'h0, oh} : 32'h0);
      chk({tag, "_re"},    {31'h0, bus.bus_read_enable}, (ph == 0) ? 32'h1 : 32'h0);
      chk({tag, "_we"},    {31'h0, bus.bus_write_enable}, 32'h0);
      chk({tag, "_grant"}, {30'h0, bus.grant}, (ph == 2) ? 32'h0 : {30'h0, oh});
      if (ph == 1) begin
        if (w) chk({tag, "_rdata1"}, bus.m1_rdata, 32'h29);
        else   chk({tag, "_rdata0"}, bus.m0_rdata, 32'h19);
      end
`ifdef REG_ARB_LOCK_EN
      if (c == drop_at) bus.m0_lock = 1'b0;
`else
      if (c == drop_at) bus.m0_req = bus.m0_req;
`endif
    end
  endtask

  initial begin
    bus.m0_req = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = 8'h0; bus.m0_wdata = 32'h0;
    bus.m1_req = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = 8'h0; bus.m1_wdata = 32'h0;
`ifdef REG_ARB_LOCK_EN
    bus.m0_lock = 1'b0; bus.m1_lock = 1'b0;
`endif

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk_idle_outputs("rst");
    chk("rst_rdata0", bus.m0_rdata, 32'h0);
    chk("rst_rdata1", bus.m1_rdata, 32'h0);
    chk("rst_addr",   {24'h0, bus.bus_address}, 32'h0);
    chk("rst_wdata",  bus.bus_write_data, 32'h0);

    // m0 write 0x04 <- 0x1, raised as reset releases
    reset = 1'b1;
    bus.m0_req = 1'b1; bus.m0_write = 1'b1; bus.m0_addr = 8'h04; bus.m0_wdata = 32'h1;
    tick();
    chk("wr_we",    {31'h0, bus.bus_write_enable}, 32'h1);
    chk("wr_re",    {31'h0, bus.bus_read_enable}, 32'h0);
    chk("wr_addr",  {24'h0, bus.bus_address}, 32'h04);
    chk("wr_wdata", bus.bus_write_data, 32'h1);
    chk("wr_grant", {30'h0, bus.grant}, 32'h1);
    chk("wr_ack_early", {31'h0, bus.m0_ack}, 32'h0);
    tick();
    chk("wr_ack",   {31'h0, bus.m0_ack}, 32'h1);
    chk("wr_we_off", {31'h0, bus.bus_write_enable}, 32'h0);
    chk("wr_grant_resp", {30'h0, bus.grant}, 32'h1);
    chk("wr_rdata0", bus.m0_rdata, 32'h0);
    bus.m0_req = 1'b0;
    tick();
    chk_idle_outputs("wr_idle");

    // m1 read 0x08 -> 0x1
    bus.m1_req = 1'b1; bus.m1_write = 1'b0; bus.m1_addr = 8'h08;
    tick();
    chk("rd_re",    {31'h0, bus.bus_read_enable}, 32'h1);
    chk("rd_we",    {31'h0, bus.bus_write_enable}, 32'h0);
    chk("rd_addr",  {24'h0, bus.bus_address}, 32'h08);
    chk("rd_grant", {30'h0, bus.grant}, 32'h2);
    tick();
    chk("rd_ack1",   {31'h0, bus.m1_ack}, 32'h1);
    chk("rd_ack0",   {31'h0, bus.m0_ack}, 32'h0);
    chk("rd_rdata1", bus.m1_rdata, 32'h1);
    chk("rd_rdata0", bus.m0_rdata, 32'h0);
    bus.m1_req = 1'b0;
    tick();
    chk_idle_outputs("rd_idle");

    // Both masters requesting: strict alternation starting with m0
    bus.m0_req = 1'b1; bus.m0_write = 1'b0; bus.m0_addr = 8'h10;
    bus.m1_req = 1'b1; bus.m1_write = 1'b0; bus.m1_addr = 8'h20;
    run_both("rr", 23, 0, 0);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    chk_idle_outputs("rr_idle");

    // Reset pulse during ACCESS of an m1 write, then re-service
    bus.m1_req = 1'b1; bus.m1_write = 1'b1; bus.m1_addr = 8'h30; bus.m1_wdata = 32'hAA;
    tick();
    chk("ab_we_pre", {31'h0, bus.bus_write_enable}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk_idle_outputs("ab_rst");
    chk("ab_addr", {24'h0, bus.bus_address}, 32'h0);
    tick();
    chk_idle_outputs("ab_hold");
    reset = 1'b1;
    tick();
    chk("ab_grant", {30'h0, bus.grant}, 32'h2);
    chk("ab_we",    {31'h0, bus.bus_write_enable}, 32'h1);
    chk("ab_wdata", bus.bus_write_data, 32'hAA);
    tick();
    chk("ab_ack1",  {31'h0, bus.m1_ack}, 32'h1);
    bus.m1_req = 1'b0;
    tick();
    chk_idle_outputs("ab_idle");
    chk("ab_writes", n_wr30, 32'd1);

`ifdef REG_ARB_LOCK_EN
    // m0 holds lock for three grants, then releases it
    bus.m0_req = 1'b1; bus.m0_write = 1'b0; bus.m0_addr = 8'h10; bus.m0_lock = 1'b1;
    bus.m1_req = 1'b1; bus.m1_write = 1'b0; bus.m1_addr = 8'h20;
    run_both("lk", 11, 3, 8);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    chk_idle_outputs("lk_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
